press_event_controller: RTL and testbench
=========================================

// Module: press_event_controller
// PURPOSE
//  Turns a raw pushbutton level into single-cycle press events: short, long and double.
//  Sits between a board button pin and the control FSMs.
//  Owns the input synchroniser, a debounce filter and one shared press/gap timer.
//  It sequences that single timer through the press and inter-press phases.
// PARAMETERS
//  CLK_PERIOD_ns   20   clock period in ns
//  DEBOUNCE_ns     60   min stable time before a level change is accepted
//  PRESS_TIMER_ns  500  hold time that qualifies a long press
//  DOUBLE_GAP_ns   300  max release gap for the second press of a double press
//  Derived tick counts use integer division, each clamped to a minimum of 1:
//    DEB_T = DEBOUNCE_ns/CLK_PERIOD_ns, LONG_T = PRESS_TIMER_ns/CLK_PERIOD_ns,
//    GAP_T = DOUBLE_GAP_ns/CLK_PERIOD_ns.
//  TW = $clog2(max(DEB_T, LONG_T, GAP_T) + 1).
// PORTS
//  clk           in   1  system clock; all state changes on rising edge
//  resetn        in   1  asynchronous, active-low reset
//  in            in   1  raw button level, asynchronous, 1 = pressed
//  short_press   out  1  1-cycle pulse: single press released before LONG_T, no second press
//  long_press    out  1  1-cycle pulse: button held for LONG_T ticks
//  double_press  out  1  1-cycle pulse: second press started within GAP_T of first release
//  held          out  1  level: high while in LONG_HOLD
// BEHAVIOUR
//  Reset
//   - All outputs, sync FFs, btn, debounce counter and timer reset to 0.
//   - FSM resets to IDLE.
//   - Reset mid-operation discards any pending event.
//   - A button still held when reset is released is treated as a new press.
//  Sync / debounce
//   - 2-FF synchroniser gives in_s.
//   - Debounce counter runs while in_s != btn and clears while in_s == btn.
//   - btn toggles on the cycle the counter reaches DEB_T.
//   - Net latency from in to btn is 2+DEB_T cycles.
//   - Pulses shorter than DEB_T cycles are ignored.
//  Timer
//   - Single TW-bit up-counter.
//   - Clears on every FSM state change and saturates at its maximum.
//  FSM (one transition per cycle; event outputs registered, high for exactly 1 cycle)
//   - IDLE: btn=1 -> PRESS1.
//   - PRESS1:
//       btn=0 -> GAP.
//       timer==LONG_T-1 with btn=1 -> pulse long_press, -> LONG_HOLD.
//       If both are true in the same cycle, release wins: -> GAP, no long_press.
//   - LONG_HOLD: held=1; btn=0 -> IDLE. No repeat events.
//   - GAP:
//       btn=1 -> pulse double_press, -> WAIT_REL.
//       timer==GAP_T-1 with btn=0 -> pulse short_press, -> IDLE.
//       If both are true in the same cycle, the press wins: double_press.
//   - WAIT_REL: btn=0 -> IDLE. Long hold of the second press is not reported.
//  Event rules
//   - At most one event output is high in any cycle.
//   - Exactly one event is produced per completed press sequence.
//   - short_press appears GAP_T cycles after the debounced release; this is the cost of double detection.
// TESTING (CLK 20, DEB 60 -> 3, LONG 500 -> 25, GAP 300 -> 15)
//  1. in=1 for 1000 ns from the sampling edge
//     -> long_press pulses exactly 30 cycles later (2+3+25); held=1 until 5 cycles after in falls.
//     -> no short_press or double_press.
//  2. in=1 for 200 ns, then 0
//     -> one short_press 20 cycles after in falls (2+3+15).
//     -> no other events.
//  3. in=1 200 ns, 0 for 100 ns, 1 for 200 ns, 0
//     -> one double_press 5 cycles after the second rise.
//     -> no short_press.
//  4. 40 ns glitch on in (2 cycles)
//     -> btn never changes; no events.
//     -> repeat with bounce (10 toggles at 20 ns, then stable 1 for 200 ns): treated as one clean short press.
//  5. resetn pulsed low while in PRESS1 with in still 1
//     -> all outputs 0 immediately (asynchronous).
//     -> after release, a long_press occurs 30 cycles later; no stale event.
//  6. Boundary: release landing on timer==LONG_T-1
//     -> no long_press; sequence completes as short_press.
//     -> second press on timer==GAP_T-1 -> double_press.

Source files
------------

// File: rtl/press_event_controller.sv
// -----------------------------------------------------------------------------
// press_event_controller
//
// Turns a raw pushbutton level into single-cycle press events (short, long,
// double). The raw level is synchronised, debounced, and then classified by a
// small FSM that reuses one shared timer for both the press-hold phase and the
// inter-press gap phase.
//
// Ports
//   clk           in   1  system clock, rising edge
//   resetn        in   1  asynchronous active-low reset
//   in            in   1  raw button level (asynchronous), 1 = pressed
//   short_press   out  1  1-cycle pulse: single press released before LONG_T
//   long_press    out  1  1-cycle pulse: button held for LONG_T ticks
//   double_press  out  1  1-cycle pulse: second press started within GAP_T
//   held          out  1  level: high while a long press is being held
// -----------------------------------------------------------------------------
module press_event_controller #(
    parameter int CLK_PERIOD_ns  = 20,
    parameter int DEBOUNCE_ns    = 60,
    parameter int PRESS_TIMER_ns = 500,
    parameter int DOUBLE_GAP_ns  = 300
) (
    input  logic clk,
    input  logic resetn,
    input  logic in,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic held
);

    // Tick counts, clamped to at least one so tiny parameter values still work.
    localparam int DEB_RAW  = DEBOUNCE_ns / CLK_PERIOD_ns;
    localparam int LONG_RAW = PRESS_TIMER_ns / CLK_PERIOD_ns;
    localparam int GAP_RAW  = DOUBLE_GAP_ns / CLK_PERIOD_ns;
    localparam int DEB_T    = (DEB_RAW  < 1) ? 1 : DEB_RAW;
    localparam int LONG_T   = (LONG_RAW < 1) ? 1 : LONG_RAW;
    localparam int GAP_T    = (GAP_RAW  < 1) ? 1 : GAP_RAW;
    localparam int MAX_DL   = (DEB_T > LONG_T) ? DEB_T : LONG_T;
    localparam int MAX_T    = (MAX_DL > GAP_T) ? MAX_DL : GAP_T;
    localparam int TW       = $clog2(MAX_T + 1);

    localparam logic [TW-1:0] DEB_LAST  = TW'(DEB_T - 1);
    localparam logic [TW-1:0] LONG_LAST = TW'(LONG_T - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_T - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] PRESS1    = 3'd1;
    localparam logic [2:0] LONG_HOLD = 3'd2;
    localparam logic [2:0] GAP       = 3'd3;
    localparam logic [2:0] WAIT_REL  = 3'd4;

    logic          sync1;
    logic          in_s;
    logic          btn;
    logic [TW-1:0] deb_cnt;
    logic [TW-1:0] timer;
    logic [2:0]    state;
    logic [2:0]    state_nx;
    logic          short_nx;
    logic          long_nx;
    logic          double_nx;

    // Two-flop synchroniser for the asynchronous button pin.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours; blocking here would collapse the
    // two synchroniser stages into one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b0;
            in_s  <= 1'b0;
        end else begin
            sync1 <= in;
            in_s  <= sync1;
        end
    end

    // Debounce: count while the synchronised level disagrees with the accepted
    // level; accept the new level on the DEB_T-th consecutive disagreeing cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            btn     <= 1'b0;
            deb_cnt <= '0;
        end else if (in_s == btn) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            btn     <= ~btn;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // Next-state and event decode. Release beats long-press in PRESS1; a new
    // press beats the short-press timeout in GAP.
    // NOTE: every signal gets a default before the case so no path can leave
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx  = state;
        short_nx  = 1'b0;
        long_nx   = 1'b0;
        double_nx = 1'b0;
        case (state)
            IDLE: begin
                if (btn) state_nx = PRESS1;
            end
            PRESS1: begin
                if (!btn) begin
                    state_nx = GAP;
                end else if (timer == LONG_LAST) begin
                    state_nx = LONG_HOLD;
                    long_nx  = 1'b1;
                end
            end
            LONG_HOLD: begin
                if (!btn) state_nx = IDLE;
            end
            GAP: begin
                if (btn) begin
                    state_nx  = WAIT_REL;
                    double_nx = 1'b1;
                end else if (timer == GAP_LAST) begin
                    state_nx = IDLE;
                    short_nx = 1'b1;
                end
            end
            WAIT_REL: begin
                if (!btn) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Shared timer restarts on every state change and saturates at all-ones.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            timer        <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
        end else begin
            state        <= state_nx;
            short_press  <= short_nx;
            long_press   <= long_nx;
            double_press <= double_nx;
            if (state_nx != state) begin
                timer <= '0;
            end else if (timer != '1) begin
                timer <= timer + 1'b1;
            end
        end
    end

    assign held = (state == LONG_HOLD);

endmodule

// File: tb/tb_press_event_controller.sv
// -----------------------------------------------------------------------------
// tb_press_event_controller
//
// Directed bench for press_event_controller at CLK 20 ns, DEB 3, LONG 25,
// GAP 15. Inputs change 1 ns after a rising edge, so the following edge is the
// sampling edge. A negedge monitor logs the cycle number of every event pulse
// and every held fall; the directed steps compare those logs against
// hand-derived cycle numbers.
// -----------------------------------------------------------------------------
module tb_press_event_controller;

    logic clk;
    logic resetn;
    logic in;
    logic short_press;
    logic long_press;
    logic double_press;
    logic held;

    press_event_controller #(
        .CLK_PERIOD_ns (20),
        .DEBOUNCE_ns   (60),
        .PRESS_TIMER_ns(500),
        .DOUBLE_GAP_ns (300)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .in          (in),
        .short_press (short_press),
        .long_press  (long_press),
        .double_press(double_press),
        .held        (held)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int   short_q[$];
    int   long_q[$];
    int   double_q[$];
    int   held_fall_q[$];
    int   btn_changes = 0;
    int   multi = 0;
    logic held_prev = 1'b0;
    logic btn_prev = 1'b0;

    always @(negedge clk) begin
        if (short_press === 1'b1)  short_q.push_back(cyc);
        if (long_press === 1'b1)   long_q.push_back(cyc);
        if (double_press === 1'b1) double_q.push_back(cyc);
        if (int'(short_press) + int'(long_press) + int'(double_press) > 1) multi++;
        if (held_prev && !held) held_fall_q.push_back(cyc);
        held_prev = held;
        if (btn_prev !== dut.btn) btn_changes++;
        btn_prev = dut.btn;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive a level for n sampling edges; returns 1 ns after the last of them.
    task automatic hold(input logic lvl, input int n);
        in = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int bs, bl, bd, bh, bb;
    int t0, tf, ts;

    task automatic mark();
        bs = short_q.size();
        bl = long_q.size();
        bd = double_q.size();
        bh = held_fall_q.size();
        bb = btn_changes;
    endtask

    initial begin
        resetn = 1'b0;
        in     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_short",  int'(short_press),  0);
        check("rst_long",   int'(long_press),   0);
        check("rst_double", int'(double_press), 0);
        check("rst_held",   int'(held),         0);
        resetn = 1'b1;
        hold(1'b0, 5);

        // 1: 50-cycle hold -> long_press 30 cycles after the rise, held drops
        //    5 cycles after the fall.
        mark();
        t0 = cyc + 1;
        hold(1'b1, 50);
        check("t1_held_during", int'(held), 1);
        tf = cyc + 1;
        hold(1'b0, 30);
        check("t1_long_cnt", long_q.size() - bl, 1);
        if (long_q.size() > bl) check("t1_long_cyc", long_q[bl], t0 + 30);
        check("t1_short_cnt", short_q.size() - bs, 0);
        check("t1_double_cnt", double_q.size() - bd, 0);
        check("t1_held_fall_cnt", held_fall_q.size() - bh, 1);
        if (held_fall_q.size() > bh) check("t1_held_fall_cyc", held_fall_q[bh], tf + 5);

        // 2: 10-cycle press -> short_press 20 cycles after the fall.
        mark();
        hold(1'b1, 10);
        tf = cyc + 1;
        hold(1'b0, 40);
        check("t2_short_cnt", short_q.size() - bs, 1);
        if (short_q.size() > bs) check("t2_short_cyc", short_q[bs], tf + 20);
        check("t2_long_cnt", long_q.size() - bl, 0);
        check("t2_double_cnt", double_q.size() - bd, 0);

        // 3: press 10, gap 5, press 10 -> double_press 5 cycles after 2nd rise.
        mark();
        hold(1'b1, 10);
        hold(1'b0, 5);
        ts = cyc + 1;
        hold(1'b1, 10);
        hold(1'b0, 40);
        check("t3_double_cnt", double_q.size() - bd, 1);
        if (double_q.size() > bd) check("t3_double_cyc", double_q[bd], ts + 5);
        check("t3_short_cnt", short_q.size() - bs, 0);
        check("t3_long_cnt", long_q.size() - bl, 0);

        // 4a: 2-cycle glitch is filtered entirely.
        mark();
        hold(1'b1, 2);
        hold(1'b0, 40);
        check("t4_glitch_btn", btn_changes - bb, 0);
        check("t4_glitch_events",
              (short_q.size() - bs) + (long_q.size() - bl) + (double_q.size() - bd), 0);

        // 4b: 10 one-cycle toggles then 10 cycles stable -> one clean short press.
        mark();
        for (int i = 0; i < 5; i++) begin
            hold(1'b1, 1);
            hold(1'b0, 1);
        end
        hold(1'b1, 10);
        tf = cyc + 1;
        hold(1'b0, 40);
        check("t4_bounce_btn", btn_changes - bb, 2);
        check("t4_bounce_short_cnt", short_q.size() - bs, 1);
        if (short_q.size() > bs) check("t4_bounce_short_cyc", short_q[bs], tf + 20);
        check("t4_bounce_other",
              (long_q.size() - bl) + (double_q.size() - bd), 0);

        // 5: reset in PRESS1 with the button held; the press restarts from
        //    reset release. Then reset in LONG_HOLD drops held at once.
        mark();
        hold(1'b1, 15);
        resetn = 1'b0;
        #1;
        check("t5_rst_outputs",
              int'(short_press) + int'(long_press) + int'(double_press) + int'(held), 0);
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        t0 = cyc + 1;
        hold(1'b1, 40);
        check("t5_long_cnt", long_q.size() - bl, 1);
        if (long_q.size() > bl) check("t5_long_cyc", long_q[bl], t0 + 30);
        check("t5_held_before_rst", int'(held), 1);
        resetn = 1'b0;
        #1;
        check("t5_held_async_clear", int'(held), 0);
        in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        hold(1'b0, 40);
        check("t5_no_stale",
              (short_q.size() - bs) + (long_q.size() - bl) + (double_q.size() - bd), 1);

        // 6a: release lands on timer==LONG_T-1 -> no long, short 20 after fall.
        mark();
        t0 = cyc + 1;
        hold(1'b1, 25);
        hold(1'b0, 40);
        check("t6a_long_cnt", long_q.size() - bl, 0);
        check("t6a_short_cnt", short_q.size() - bs, 1);
        if (short_q.size() > bs) check("t6a_short_cyc", short_q[bs], t0 + 45);

        // 6b: one cycle longer hold -> long_press.
        mark();
        t0 = cyc + 1;
        hold(1'b1, 26);
        hold(1'b0, 30);
        check("t6b_long_cnt", long_q.size() - bl, 1);
        if (long_q.size() > bl) check("t6b_long_cyc", long_q[bl], t0 + 30);
        check("t6b_short_cnt", short_q.size() - bs, 0);

        // 6c: second press lands on timer==GAP_T-1 -> double wins.
        mark();
        t0 = cyc + 1;
        hold(1'b1, 25);
        hold(1'b0, 15);
        ts = cyc + 1;
        hold(1'b1, 5);
        hold(1'b0, 40);
        check("t6c_double_cnt", double_q.size() - bd, 1);
        if (double_q.size() > bd) check("t6c_double_cyc", double_q[bd], ts + 5);
        check("t6c_short_cnt", short_q.size() - bs, 0);
        check("t6c_long_cnt", long_q.size() - bl, 0);

        // 6d: second press one cycle late -> short for the first press, then a
        //     second independent short press.
        mark();
        t0 = cyc + 1;
        hold(1'b1, 25);
        hold(1'b0, 16);
        hold(1'b1, 5);
        hold(1'b0, 40);
        check("t6d_double_cnt", double_q.size() - bd, 0);
        check("t6d_short_cnt", short_q.size() - bs, 2);
        if (short_q.size() > bs) check("t6d_short_cyc", short_q[bs], t0 + 45);

        check("one_event_per_cycle", multi, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
